// File: rtl/rom_stream_reader_pkg.sv
// Shared widths, FSM state encodings and limits for the ROM stream reader.
package rom_rd_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned MAX_COUNT  = 4096;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_ISSUE   = 3'd1;
    localparam state_t S_WAIT    = 3'd2;
    localparam state_t S_CAPTURE = 3'd3;
    localparam state_t S_HOLD    = 3'd4;

endpackage

// File: rtl/rom_stream_reader_if.sv
// Control, ROM-side and byte-stream signals of the ROM stream reader.
interface rom_stream_reader_if
    import rom_rd_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // Reader side: consumes control and ROM data, drives ROM address and stream.
    modport master (
        input  start, start_addr, count, rom_data, out_ready,
        output busy, done, rom_addr, out_data, out_valid
    );

    // Environment side: issues requests, models the ROM, sinks the stream.
    modport slave (
        output start, start_addr, count, rom_data, out_ready,
        input  busy, done, rom_addr, out_data, out_valid
    );

endinterface

// File: rtl/rom_stream_reader_rd_latency_timer.sv
// 2-bit loadable down-counter that flags the decrement which reaches zero.
module rd_latency_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [1:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_c_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High in the cycle whose decrement brings the count to zero.
    assign zero_c_o = dec_i && (cnt_q == 2'd1);

endmodule

// File: rtl/rom_stream_reader.sv
// Walks consecutive ROM addresses, one read outstanding, and streams each byte out.
module rom_stream_reader
    import rom_rd_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    rom_stream_reader_if.master  bus
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned MAX_CNT_I = (ADDR_W == ADDR_W_DEF) ? MAX_COUNT : (1 << ADDR_W);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CNT_I);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_zero;
    logic              accept;
    logic              last_hs;
    logic [CNT_W-1:0]  count_clamped;

    rd_latency_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (2'(RD_LAT)),
        .dec_i      (tmr_dec),
        .zero_c_o   (tmr_zero)
    );

    assign accept        = bus.start && (bus.count != '0);
    assign last_hs       = bus.out_ready && (rem_q == CNT_W'(1));
    assign count_clamped = (bus.count > MAX_CNT) ? MAX_CNT : bus.count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_ISSUE;
            S_ISSUE:   state_d = (RD_LAT == 0) ? S_CAPTURE : S_WAIT;
            S_WAIT:    if (tmr_zero) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_HOLD;
            S_HOLD:    if (bus.out_ready) state_d = last_hs ? S_IDLE : S_ISSUE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        rem_d       = rem_q;
        rom_addr_d  = rom_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d = bus.start_addr;
                    rem_d  = count_clamped;
                    busy_d = 1'b1;
                end
            end
            S_ISSUE: begin
                rom_addr_d = addr_q;
                tmr_load   = (RD_LAT != 0);
            end
            S_WAIT: begin
                tmr_dec = 1'b1;
            end
            S_CAPTURE: begin
                out_data_d  = bus.rom_data;
                out_valid_d = 1'b1;
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    rem_d       = rem_q - CNT_W'(1);
                    if (last_hs) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            rem_q       <= '0;
            rom_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            rom_addr_q  <= rom_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader: one zero-latency and one RD_LAT=3 instance.
module tb_rom_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst3;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    rom_stream_reader_if #(.ADDR_W(12), .DATA_W(8)) if0 ();
    rom_stream_reader_if #(.ADDR_W(12), .DATA_W(8)) if3 ();

    rom_stream_reader #(.ADDR_W(12), .DATA_W(8), .RD_LAT(0)) dut0 (
        .clk(clk), .reset(rst0), .bus(if0.master));
    rom_stream_reader #(.ADDR_W(12), .DATA_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(rst3), .bus(if3.master));

    // ROM models: combinational for dut0, three cycles of address delay for dut3.
    assign if0.rom_data = if0.rom_addr[7:0] ^ 8'hA5;
    logic [11:0] p3 [3];
    always @(posedge clk) begin
        p3[0] <= if3.rom_addr;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign if3.rom_data = p3[2][7:0] ^ 8'hA5;

    logic [7:0]  qd0[$], qd3[$];
    logic [11:0] qa0[$], qa3[$];
    int unsigned rise0[$], rise3[$];
    int unsigned t0, t3;
    int unsigned done_cnt0 = 0, done_cnt3 = 0;
    logic pv0 = 1'b0, pv3 = 1'b0;

    always @(negedge clk) begin
        if (if0.out_valid && !pv0) rise0.push_back(cyc);
        pv0 <= if0.out_valid;
        if (if0.out_valid && if0.out_ready) begin
            if (qd0.size() == 0) check("extra_byte0", 32'd1, 32'd0);
            else begin
                check("data0", 32'(if0.out_data), 32'(qd0.pop_front()));
                check("addr0", 32'(if0.rom_addr), 32'(qa0.pop_front()));
            end
        end
        if (if0.done) begin
            done_cnt0 <= done_cnt0 + 1;
            check("busy_in_done0", 32'(if0.busy), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (if3.out_valid && !pv3) rise3.push_back(cyc);
        pv3 <= if3.out_valid;
        if (if3.out_valid && if3.out_ready) begin
            if (qd3.size() == 0) check("extra_byte3", 32'd1, 32'd0);
            else begin
                check("data3", 32'(if3.out_data), 32'(qd3.pop_front()));
                check("addr3", 32'(if3.rom_addr), 32'(qa3.pop_front()));
            end
        end
        if (if3.done) begin
            done_cnt3 <= done_cnt3 + 1;
            check("busy_in_done3", 32'(if3.busy), 32'd0);
        end
    end

    // Called at a negedge: the following posedge samples start.
    task automatic start0(input logic [11:0] a, input logic [12:0] n);
        logic [11:0] ai;
        int unsigned m;
        m = (n > 13'd4096) ? 4096 : int'(n);
        if0.start = 1'b1; if0.start_addr = a; if0.count = n;
        t0 = cyc + 1;
        rise0.delete();
        for (int i = 0; i < int'(m); i++) begin
            ai = a + 12'(i);
            qa0.push_back(ai);
            qd0.push_back(ai[7:0] ^ 8'hA5);
        end
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    task automatic start3(input logic [11:0] a, input logic [12:0] n);
        logic [11:0] ai;
        t3 = cyc + 1;
        if3.start = 1'b1; if3.start_addr = a; if3.count = n;
        rise3.delete();
        for (int i = 0; i < int'(n); i++) begin
            ai = a + 12'(i);
            qa3.push_back(ai);
            qd3.push_back(ai[7:0] ^ 8'hA5);
        end
        @(negedge clk);
        if3.start = 1'b0;
    endtask

    task automatic wait_done0(input string tag);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (if0.done) break;
        end
        check(tag, 32'(if0.done), 32'd1);
    endtask

    task automatic wait_done3(input string tag);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (if3.done) break;
        end
        check(tag, 32'(if3.done), 32'd1);
    endtask

    int unsigned dc;

    initial begin
        rst0 = 1'b1; rst3 = 1'b1;
        if0.start = 1'b0; if0.start_addr = '0; if0.count = '0; if0.out_ready = 1'b1;
        if3.start = 1'b0; if3.start_addr = '0; if3.count = '0; if3.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_valid0", 32'(if0.out_valid), 32'd0);
        check("rst_busy0", 32'(if0.busy), 32'd0);
        check("rst_done0", 32'(if0.done), 32'd0);
        check("rst_addr0", 32'(if0.rom_addr), 32'd0);
        check("rst_data0", 32'(if0.out_data), 32'd0);
        rst0 = 1'b0; rst3 = 1'b0;
        @(negedge clk);

        // Basic read
        start0(12'h000, 13'd4);
        check("t1_busy", 32'(if0.busy), 32'd1);
        dc = done_cnt0;
        wait_done0("t1_done");
        @(negedge clk);
        check("t1_done_pulse", 32'(if0.done), 32'd0);
        check("t1_first_lat", 32'(rise0[0] - t0), 32'd2);
        check("t1_period", 32'(rise0[1] - rise0[0]), 32'd3);
        repeat (2) @(negedge clk);
        check("t1_done_once", 32'(done_cnt0 - dc), 32'd1);

        // Backpressure on byte 2
        start0(12'h000, 13'd3);
        for (int k = 0; k < 20 && !if0.out_valid; k++) @(negedge clk);
        @(negedge clk);
        if0.out_ready = 1'b0;
        for (int k = 0; k < 20 && !if0.out_valid; k++) @(negedge clk);
        check("t2_valid_rise", 32'(if0.out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_hold_valid", 32'(if0.out_valid), 32'd1);
            check("t2_hold_data", 32'(if0.out_data), 32'hA4);
            check("t2_hold_addr", 32'(if0.rom_addr), 32'h001);
        end
        if0.out_ready = 1'b1;
        wait_done0("t2_done");
        @(negedge clk);

        // Address wrap, then a zero-count start
        start0(12'hFFE, 13'd4);
        wait_done0("t3_done");
        @(negedge clk);
        dc = done_cnt0;
        if0.start = 1'b1; if0.start_addr = 12'h123; if0.count = 13'd0;
        @(negedge clk);
        if0.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_zero_busy", 32'(if0.busy), 32'd0);
        end
        check("t3_zero_nodone", 32'(done_cnt0 - dc), 32'd0);
        check("t3_addr_held", 32'(if0.rom_addr), 32'h001);

        // start while busy is ignored; start in the done cycle is accepted
        start0(12'h040, 13'd3);
        @(negedge clk);
        if0.start = 1'b1; if0.start_addr = 12'h100; if0.count = 13'd5;
        @(negedge clk);
        if0.start = 1'b0;
        wait_done0("t6_done");
        start0(12'h050, 13'd2);
        check("t6_restart_busy", 32'(if0.busy), 32'd1);
        wait_done0("t6_done2");
        repeat (2) @(negedge clk);

        // Latency RD_LAT=3
        start3(12'h010, 13'd2);
        wait_done3("t4_done");
        @(negedge clk);
        check("t4_first_lat", 32'(rise3[0] - t3), 32'd5);
        check("t4_period", 32'(rise3[1] - rise3[0]), 32'd6);

        // Reset during WAIT of byte 2, then restart
        start3(12'h000, 13'd8);
        for (int k = 0; k < 20 && !if3.out_valid; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t5_pre_addr", 32'(if3.rom_addr), 32'h001);
        #1 rst3 = 1'b1;
        #1;
        check("t5_rst_valid", 32'(if3.out_valid), 32'd0);
        check("t5_rst_busy", 32'(if3.busy), 32'd0);
        check("t5_rst_addr", 32'(if3.rom_addr), 32'd0);
        check("t5_rst_data", 32'(if3.out_data), 32'd0);
        check("t5_rst_done", 32'(if3.done), 32'd0);
        qd3.delete(); qa3.delete();
        dc = done_cnt3;
        @(negedge clk);
        rst3 = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_no_done", 32'(done_cnt3 - dc), 32'd0);
        start3(12'h020, 13'd1);
        wait_done3("t5_done");
        repeat (2) @(negedge clk);
        check("t5_done_once", 32'(done_cnt3 - dc), 32'd1);

        check("sb_empty0", 32'(qd0.size()), 32'd0);
        check("sb_empty3", 32'(qd3.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
